// File: rtl/p_file_loader.sv
// p_file_loader: streams a ZX81 .P image into RAM while holding the CPU off the bus
module p_file_loader #(
    parameter logic [15:0] LOAD_BASE = 16'h4009,
    parameter logic [15:0] ELINE_OFS = 16'h000B,
    parameter logic [15:0] RAM_TOP   = 16'h43FF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busrq_n,
    input  logic        busak_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        ld_sel,
    output logic [15:0] ld_a,
    output logic [7:0]  ld_din,
    output logic        ld_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] byte_count
);
    typedef enum logic [2:0] {IDLE, REQ, LOAD, DRAIN, REL} state_t;

    state_t      state, state_nx;
    logic [15:0] len;
    logic [7:0]  eline_lo;
    logic        wr, set_err;

    // The accepted byte's image offset is byte_count, since every write advances it by one
    logic [15:0] addr, eline, len_eff;
    logic        addr_oob, hi_byte, eline_ok, last_off;
    assign addr     = LOAD_BASE + byte_count;
    assign addr_oob = addr > RAM_TOP;
    assign hi_byte  = byte_count == ELINE_OFS + 16'd1;
    assign eline    = {s_data, eline_lo};
    assign eline_ok = (eline > LOAD_BASE + ELINE_OFS + 16'd1) && (eline - 16'd1 <= RAM_TOP);
    assign len_eff  = hi_byte ? eline - LOAD_BASE : len;
    assign last_off = byte_count == len_eff - 16'd1;

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state plus per-byte write/error decisions
    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        set_err  = 1'b0;
        case (state)
            IDLE:  state_nx = start ? REQ : IDLE;
            REQ: begin
                if (abort) begin
                    state_nx = REL;
                    set_err  = 1'b1;
                end else if (!busak_n) state_nx = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_nx = REL;
                    set_err  = 1'b1;
                end else if (s_valid) begin
                    if (addr_oob || (hi_byte && !eline_ok)) begin
                        set_err  = 1'b1;
                        state_nx = s_last ? REL : DRAIN;
                    end else begin
                        wr = 1'b1;
                        if (last_off) state_nx = s_last ? REL : DRAIN;
                        else if (s_last) begin
                            set_err  = 1'b1;
                            state_nx = REL;
                        end
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = REL;
                    set_err  = 1'b1;
                end else if (s_valid && s_last) state_nx = REL;
            end
            REL:     state_nx = busak_n ? IDLE : REL;
            default: state_nx = IDLE;
        endcase
    end

    // Bus and stream controls; ld_sel stays up while a final registered write drains out
    always_comb begin
        busrq_n = !(state == REQ || state == LOAD);
        s_ready = state == LOAD || state == DRAIN;
        ld_sel  = state == LOAD || ld_we;
        busy    = state != IDLE;
    end

    // Registered write port, length capture and status
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ld_we      <= 1'b0;
            ld_a       <= 16'h0000;
            ld_din     <= 8'h00;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= 16'h0000;
            len        <= 16'hFFFF;
            eline_lo   <= 8'h00;
        end else begin
            ld_we <= wr;
            done  <= state == REL && busak_n && !error;
            if (wr) begin
                ld_a       <= addr;
                ld_din     <= s_data;
                byte_count <= byte_count + 16'd1;
            end
            if (state == LOAD && s_valid && byte_count == ELINE_OFS) eline_lo <= s_data;
            if (state == LOAD && s_valid && hi_byte && eline_ok) len <= eline - LOAD_BASE;
            if (state == IDLE && start) begin
                error      <= 1'b0;
                byte_count <= 16'h0000;
                len        <= 16'hFFFF;
            end else if (set_err) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_p_file_loader.sv
// tb_p_file_loader: directed checks of the .P loader against hand-computed expectations
module tb_p_file_loader;
    logic        clk_sys = 0, reset = 1, start = 0, abort = 0, busak_n = 1;
    logic [7:0]  s_data = 0;
    logic        s_valid = 0, s_last = 0;
    logic        busrq_n, s_ready, ld_sel, ld_we, busy, done, error;
    logic [15:0] ld_a, byte_count;
    logic [7:0]  ld_din;

    int   n_cmp = 0, n_err = 0, wr_cnt = 0, done_cnt = 0;
    logic auto_ak = 1;
    logic [7:0] img [0:31];

    p_file_loader dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
        .busrq_n(busrq_n), .busak_n(busak_n), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .ld_sel(ld_sel), .ld_a(ld_a),
        .ld_din(ld_din), .ld_we(ld_we), .busy(busy), .done(done), .error(error),
        .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Simple CPU: acknowledge follows request half a cycle later
    always @(negedge clk_sys) if (auto_ak) busak_n = busrq_n;

    // Write monitor: every strobe must be selected, sequential and carry the image byte
    always @(negedge clk_sys) begin
        if (ld_we) begin
            chk("we_sel", ld_sel, 1);
            chk("wr_addr", ld_a, 16'h4009 + wr_cnt[15:0]);
            chk("wr_data", ld_din, img[wr_cnt[4:0]]);
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic build(input logic [15:0] eline);
        for (int i = 0; i < 32; i++) img[i] = 8'(i * 7 + 8'h21);
        img[11] = eline[7:0];
        img[12] = eline[15:8];
    endtask

    task automatic go();
        wr_cnt = 0;
        done_cnt = 0;
        @(negedge clk_sys) start = 1;
        @(negedge clk_sys) start = 0;
        chk("err_clr", error, 0);
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic ab);
        logic ok;
        ok = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk_sys);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 0, 1);
        else begin
            s_data = d; s_valid = 1; s_last = l; abort = ab;
            @(posedge clk_sys) #1;
            s_valid = 0; s_last = 0; abort = 0;
        end
    endtask

    task automatic send(input int n, input int last_i);
        for (int i = 0; i < n; i++) push(img[i], i == last_i, 0);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk_sys);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_busrq_n"}, busrq_n, 1);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_ld_sel"}, ld_sel, 0);
        chk({tag, "_ld_we"}, ld_we, 0);
        chk({tag, "_ld_a"}, ld_a, 0);
        chk({tag, "_ld_din"}, ld_din, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_count"}, byte_count, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        reset_vals("rst");
        reset = 0;
        @(negedge clk_sys);

        build(16'h4019);
        go();
        send(16, 15);
        wait_idle();
        chk("nom_writes", wr_cnt, 16);
        chk("nom_count", byte_count, 16);
        chk("nom_done", done_cnt, 1);
        chk("nom_error", error, 0);
        chk("nom_busrq_n", busrq_n, 1);
        chk("nom_sel", ld_sel, 0);

        auto_ak = 0;
        busak_n = 1;
        go();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            chk("hs_busrq_n", busrq_n, 0);
            chk("hs_sel", ld_sel, 0);
            chk("hs_ready", s_ready, 0);
        end
        busak_n = 0;
        @(negedge clk_sys);
        chk("hs_sel_load", ld_sel, 1);
        chk("hs_ready_load", s_ready, 1);
        auto_ak = 1;
        send(16, 15);
        wait_idle();
        chk("hs_writes", wr_cnt, 16);
        chk("hs_done", done_cnt, 1);

        go();
        send(20, 19);
        wait_idle();
        chk("trail_writes", wr_cnt, 16);
        chk("trail_count", byte_count, 16);
        chk("trail_done", done_cnt, 1);
        chk("trail_error", error, 0);

        go();
        send(10, 9);
        wait_idle();
        chk("short_writes", wr_cnt, 10);
        chk("short_error", error, 1);
        chk("short_done", done_cnt, 0);
        chk("short_busrq_n", busrq_n, 1);

        build(16'h4500);
        go();
        send(13, -1);
        @(negedge clk_sys);
        chk("bad_err_at_hi", error, 1);
        chk("bad_drain_busy", busy, 1);
        for (int i = 13; i < 20; i++) push(img[i], i == 19, 0);
        wait_idle();
        chk("bad_writes", wr_cnt, 12);
        chk("bad_count", byte_count, 12);
        chk("bad_done", done_cnt, 0);

        build(16'h4019);
        go();
        send(5, -1);
        push(img[5], 0, 1);
        @(negedge clk_sys);
        chk("abt_error", error, 1);
        chk("abt_busrq_n", busrq_n, 1);
        wait_idle();
        chk("abt_writes", wr_cnt, 5);
        chk("abt_count", byte_count, 5);
        chk("abt_done", done_cnt, 0);
        chk("abt_idle", busy, 0);

        go();
        send(4, -1);
        @(negedge clk_sys);
        chk("mid_busy", busy, 1);
        reset = 1;
        #1;
        reset_vals("arst");
        @(negedge clk_sys) reset = 0;
        repeat (2) @(negedge clk_sys);
        chk("arst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
